// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: pops the vc0/vc1 FIFOs (vc0 strict priority), routes each word to d0/d1 by its MSB.
// Latency: pop in N, push in N+2; sustains 1 word/cycle. Optional pop counters: VC_POP_COUNT_EN.
// Backpressure: either destination pause blocks pops; up to 2 words already in flight still complete.
module vc_pop_arbiter #(
    parameter int DATA_SIZE = 6,
    parameter int COUNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic                 fifo_error_vc0,
    input  logic                 fifo_error_vc1,
    input  logic [DATA_SIZE-1:0] data_mux_0,
    input  logic [DATA_SIZE-1:0] data_mux_1,
    input  logic                 fifo_pause_d0,
    input  logic                 fifo_pause_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic                 arb_idle,
    output logic                 arb_error
`ifdef VC_POP_COUNT_EN
    ,
    output logic [COUNT_W-1:0]   pop_count_vc0,
    output logic [COUNT_W-1:0]   pop_count_vc1
`endif
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   err_in;
    logic                   pop_en;
    logic                   s1_vld;
    logic                   s1_sel;
    logic                   drain;
    logic [DATA_SIZE-1:0]   word;

    assign err_in = fifo_error_vc0 | fifo_error_vc1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_IDLE;
            S_IDLE: begin
                if (err_in)
                    state_nxt = S_ERROR;
                else if (!fifo_empty_vc0 || !fifo_empty_vc1)
                    state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (err_in)
                    state_nxt = S_ERROR;
                else if (fifo_empty_vc0 && fifo_empty_vc1 && !s1_vld)
                    state_nxt = S_IDLE;
            end
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_INIT;
        endcase

        // Both pauses gate the pop: the destination is only known once the word is read.
        pop_en  = !reset && (state == S_ACTIVE) && !fifo_pause_d0 && !fifo_pause_d1;
        pop_vc0 = pop_en && !fifo_empty_vc0;
        pop_vc1 = pop_en && fifo_empty_vc0 && !fifo_empty_vc1;

        // A word read back while the FSM is heading into ERROR is dropped.
        word  = s1_sel ? data_mux_1 : data_mux_0;
        drain = s1_vld && (state_nxt != S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            s1_vld    <= 1'b0;
            s1_sel    <= 1'b0;
            push_d0   <= 1'b0;
            push_d1   <= 1'b0;
            data_d0   <= '0;
            data_d1   <= '0;
            arb_idle  <= 1'b0;
            arb_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            s1_vld    <= (pop_vc0 || pop_vc1) && (state_nxt != S_ERROR);
            s1_sel    <= pop_vc1;
            push_d0   <= drain && !word[DATA_SIZE-1];
            push_d1   <= drain && word[DATA_SIZE-1];
            if (drain && !word[DATA_SIZE-1])
                data_d0 <= word;
            if (drain && word[DATA_SIZE-1])
                data_d1 <= word;
            arb_idle  <= (state == S_IDLE) && (state_nxt == S_IDLE) && !s1_vld;
            arb_error <= (state_nxt == S_ERROR);
        end
    end

`ifdef VC_POP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_count_vc0 <= '0;
            pop_count_vc1 <= '0;
        end else if (state != S_ERROR) begin
            if (pop_vc0)
                pop_count_vc0 <= pop_count_vc0 + COUNT_W'(1);
            if (pop_vc1)
                pop_count_vc1 <= pop_count_vc1 + COUNT_W'(1);
        end
    end
`endif

endmodule
